mips_cpu_alu_muldiv_seq: RTL and testbench

- Parametrised, multi-cycle successor to the single-cycle HI/LO multiply/divide unit.
- Iterative shift-add multiplier and radix-2 restoring divider, one bit per cycle, sharing a single 2*WIDTH datapath.
- Owns the HI/LO registers and issues start/busy/done handshakes to the pipeline's execute stage, which stalls MFHI/MFLO while busy.

---
 rtl/mips_cpu_alu_muldiv_seq.sv | 194 +++++++++++++++++++
 tb/tb_mips_cpu_alu_muldiv_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_alu_muldiv_seq.sv
// rtl/mips_cpu_alu_muldiv_seq.sv - multi-cycle HI/LO multiply/divide unit (shift-add / restoring, one bit per cycle)
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-high reset, clears all state
//   abort    (only with MULDIV_ABORT_EN) flushes an in-flight mult/div without writing hi/lo
//   a, b     operands (multiplicand/dividend/MT data, multiplier/divisor)
//   op       000 DIVU, 001 MULTU, 010 DIV, 011 MULT, 100 MTHI, 101 MTLO, 11x no-op
//   start    request, sampled only while idle
//   busy     high while a mult/div is in flight
//   done     one-cycle pulse when hi/lo were just updated by a mult/div
//   div_zero pulses with done when a divide had a zero divisor
//   hi, lo   HI/LO registers
//
// Optional feature macro: MULDIV_ABORT_EN (adds the abort input).

module mips_cpu_alu_muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
`ifdef MULDIV_ABORT_EN
    input  logic             abort,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state, state_n;
    logic [2*WIDTH-1:0] acc, acc_n;      // product, or {remainder, quotient}
    logic [WIDTH-1:0]   opb, opb_n;      // multiplicand or divisor magnitude
    logic [CW-1:0]      cnt, cnt_n;
    logic               is_div, is_div_n;
    logic               sa, sa_n, sb, sb_n;
    logic               dz, dz_n;
    logic               busy_n, done_n, div_zero_n;
    logic [WIDTH-1:0]   hi_n, lo_n;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] mul_step, div_step, prod_neg;
    logic [WIDTH-1:0]   quo, rem;

    // Signed ops work on magnitudes; the most-negative value maps to
    // 1 followed by zeros, which is its correct unsigned magnitude.
    assign a_mag = (op[1] && a[WIDTH-1]) ? -a : a;
    assign b_mag = (op[1] && b[WIDTH-1]) ? -b : b;

    // Multiply: add multiplicand into the upper half when the LSB is set,
    // then shift the whole accumulator right, carry entering at the top.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    assign mul_step = {mul_sum, acc[WIDTH-1:1]};

    // Divide: the upper WIDTH+1 bits of the left-shifted accumulator are
    // the partial remainder; keep the subtraction only if it did not borrow.
    assign div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opb};
    assign div_step  = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                        : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    assign prod_neg = -acc;
    assign quo      = (sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem      = sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_comb begin
        state_n    = state;
        acc_n      = acc;
        opb_n      = opb;
        cnt_n      = cnt;
        is_div_n   = is_div;
        sa_n       = sa;
        sb_n       = sb;
        dz_n       = dz;
        hi_n       = hi;
        lo_n       = lo;
        busy_n     = busy;
        done_n     = 1'b0;
        div_zero_n = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    case (op)
                        3'b100: hi_n = a;
                        3'b101: lo_n = a;
                        3'b000, 3'b001, 3'b010, 3'b011: begin
                            is_div_n = ~op[0];
                            sa_n     = op[1] & a[WIDTH-1];
                            sb_n     = op[1] & b[WIDTH-1];
                            cnt_n    = '0;
                            busy_n   = 1'b1;
                            if (op[0]) begin
                                acc_n = {{WIDTH{1'b0}}, b_mag};
                                opb_n = a_mag;
                            end else begin
                                acc_n = {{WIDTH{1'b0}}, a_mag};
                                opb_n = b_mag;
                            end
                            if (!op[0] && b == '0) begin
                                dz_n    = 1'b1;
                                state_n = FIX;
                            end else begin
                                dz_n    = 1'b0;
                                state_n = CALC;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            CALC: begin
                acc_n = is_div ? div_step : mul_step;
                cnt_n = cnt + CW'(1);
                if (cnt == CW'(WIDTH - 1))
                    state_n = FIX;
            end
            FIX: begin
                if (!dz) begin
                    if (is_div) begin
                        hi_n = rem;
                        lo_n = quo;
                    end else if (sa ^ sb) begin
                        hi_n = prod_neg[2*WIDTH-1:WIDTH];
                        lo_n = prod_neg[WIDTH-1:0];
                    end else begin
                        hi_n = acc[2*WIDTH-1:WIDTH];
                        lo_n = acc[WIDTH-1:0];
                    end
                end
                busy_n     = 1'b0;
                done_n     = 1'b1;
                div_zero_n = dz;
                state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase

`ifdef MULDIV_ABORT_EN
        // Flush wins over the FIX write.
        if (abort && state != IDLE) begin
            state_n    = IDLE;
            busy_n     = 1'b0;
            done_n     = 1'b0;
            div_zero_n = 1'b0;
            hi_n       = hi;
            lo_n       = lo;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            acc      <= '0;
            opb      <= '0;
            cnt      <= '0;
            is_div   <= 1'b0;
            sa       <= 1'b0;
            sb       <= 1'b0;
            dz       <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            state    <= state_n;
            acc      <= acc_n;
            opb      <= opb_n;
            cnt      <= cnt_n;
            is_div   <= is_div_n;
            sa       <= sa_n;
            sb       <= sb_n;
            dz       <= dz_n;
            hi       <= hi_n;
            lo       <= lo_n;
            busy     <= busy_n;
            done     <= done_n;
            div_zero <= div_zero_n;
        end
    end

endmodule

// File: tb/tb_mips_cpu_alu_muldiv_seq.sv
// tb/tb_mips_cpu_alu_muldiv_seq.sv - directed self-checking bench for mips_cpu_alu_muldiv_seq

module tb_mips_cpu_alu_muldiv_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] a, b;
    logic [2:0]   op;
    logic         start;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;
`ifdef MULDIV_ABORT_EN
    logic         abort = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    mips_cpu_alu_muldiv_seq #(.WIDTH(W)) dut (
        .clk(clk),
        .reset(reset),
`ifdef MULDIV_ABORT_EN
        .abort(abort),
`endif
        .a(a),
        .b(b),
        .op(op),
        .start(start),
        .busy(busy),
        .done(done),
        .div_zero(div_zero),
        .hi(hi),
        .lo(lo)
    );

    always #5 clk = ~clk;

    // Drive a request in the current cycle and release it after the edge.
    task automatic issue_now(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
        op = o; a = av; b = bv; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        a = 32'hA5A5_5A5A; b = 32'h5A5A_A5A5;
    endtask

    task automatic issue(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
        @(negedge clk);
        issue_now(o, av, bv);
    endtask

    // Returns at the negedge where done is seen; edges = edges after E0.
    task automatic wait_done(output int edges, output int busy_cnt, output bit ok);
        ok = 1'b0; busy_cnt = 0; edges = 0;
        for (int j = 1; j <= 100; j++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1; edges = j - 1;
                break;
            end
            if (busy) busy_cnt++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; op = 3'b110; a = '0; b = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, done, div_zero, hi, lo} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got busy=%b done=%b dz=%b hi=%h lo=%h, want all 0", busy, done, div_zero, hi, lo);
        end
        reset = 1'b0;
    endtask

    task automatic test_multu;
        int e, bc; bit ok;
        issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(e, bc, ok);
        n_cmp++;
        if (!ok || e !== 33) begin n_bad++; $display("FAIL multu_latency: got ok=%0d edges=%0d, want 33", ok, e); end
        n_cmp++;
        if (bc !== 33) begin n_bad++; $display("FAIL multu_busy_cycles: got %0d, want 33", bc); end
        n_cmp++;
        if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
            n_bad++; $display("FAIL multu_result: got hi=%h lo=%h, want fffffffe 00000001", hi, lo);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL multu_done_pulse: got done=%b busy=%b, want 0 0", done, busy); end
    endtask

    task automatic test_mult;
        int e, bc; bit ok;
        issue(3'b011, 32'hFFFF_FFFD, 32'd7);
        wait_done(e, bc, ok);
        n_cmp++;
        if (!ok || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
            n_bad++; $display("FAIL mult_neg3x7: got ok=%0d hi=%h lo=%h, want ffffffff ffffffeb", ok, hi, lo);
        end
        issue(3'b011, 32'h8000_0000, 32'h8000_0000);
        wait_done(e, bc, ok);
        n_cmp++;
        if (!ok || hi !== 32'h4000_0000 || lo !== 32'h0) begin
            n_bad++; $display("FAIL mult_minxmin: got ok=%0d hi=%h lo=%h, want 40000000 00000000", ok, hi, lo);
        end
    endtask

    task automatic test_div;
        int e, bc; bit ok;
        issue(3'b010, 32'hFFFF_FFF9, 32'd2);
        wait_done(e, bc, ok);
        n_cmp++;
        if (!ok || e !== 33 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD || div_zero !== 1'b0) begin
            n_bad++; $display("FAIL div_neg7by2: got ok=%0d edges=%0d hi=%h lo=%h dz=%b, want 33 ffffffff fffffffd 0", ok, e, hi, lo, div_zero);
        end
        issue(3'b000, 32'd7, 32'd2);
        wait_done(e, bc, ok);
        n_cmp++;
        if (!ok || hi !== 32'd1 || lo !== 32'd3) begin
            n_bad++; $display("FAIL divu_7by2: got ok=%0d hi=%h lo=%h, want 1 3", ok, hi, lo);
        end
        issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(e, bc, ok);
        n_cmp++;
        if (!ok || hi !== 32'h0 || lo !== 32'h8000_0000) begin
            n_bad++; $display("FAIL div_overflow: got ok=%0d hi=%h lo=%h, want 0 80000000", ok, hi, lo);
        end
    endtask

    task automatic test_mt_divzero;
        int e, bc; bit ok;
        issue(3'b100, 32'h1234, 32'h0);
        @(negedge clk);
        n_cmp++;
        if (hi !== 32'h1234 || busy !== 1'b0 || done !== 1'b0) begin
            n_bad++; $display("FAIL mthi: got hi=%h busy=%b done=%b, want 1234 0 0", hi, busy, done);
        end
        issue(3'b101, 32'h5678, 32'h0);
        @(negedge clk);
        n_cmp++;
        if (lo !== 32'h5678 || hi !== 32'h1234 || busy !== 1'b0) begin
            n_bad++; $display("FAIL mtlo: got hi=%h lo=%h busy=%b, want 1234 5678 0", hi, lo, busy);
        end
        issue(3'b110, 32'hFFFF, 32'h0);
        @(negedge clk);
        n_cmp++;
        if (hi !== 32'h1234 || lo !== 32'h5678 || busy !== 1'b0) begin
            n_bad++; $display("FAIL noop: got hi=%h lo=%h busy=%b, want 1234 5678 0", hi, lo, busy);
        end
        issue(3'b000, 32'd5, 32'd0);
        wait_done(e, bc, ok);
        n_cmp++;
        if (!ok || e !== 1 || div_zero !== 1'b1 || hi !== 32'h1234 || lo !== 32'h5678) begin
            n_bad++; $display("FAIL div_zero: got ok=%0d edges=%0d dz=%b hi=%h lo=%h, want 1 1 1234 5678", ok, e, div_zero, hi, lo);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || div_zero !== 1'b0) begin
            n_bad++; $display("FAIL div_zero_pulse: got done=%b dz=%b, want 0 0", done, div_zero);
        end
    endtask

    task automatic test_busy_ignore_and_reset;
        int e, bc; bit ok;
        bit seen;
        issue(3'b001, 32'd3, 32'd4);
        repeat (5) @(negedge clk);
        issue_now(3'b100, 32'hDEAD, 32'h0);
        wait_done(e, bc, ok);
        n_cmp++;
        if (!ok || hi !== 32'h0 || lo !== 32'd12) begin
            n_bad++; $display("FAIL start_while_busy: got ok=%0d hi=%h lo=%h, want 0 0000000c", ok, hi, lo);
        end
        issue(3'b001, 32'd5, 32'd6);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            n_bad++; $display("FAIL async_reset: got busy=%b hi=%h lo=%h, want 0 0 0", busy, hi, lo);
        end
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin n_bad++; $display("FAIL reset_discard: got activity=%b, want 0", seen); end
    endtask

    task automatic test_back_to_back;
        int e, bc; bit ok;
        issue(3'b001, 32'd2, 32'd3);
        wait_done(e, bc, ok);
        n_cmp++;
        if (!ok || hi !== 32'h0 || lo !== 32'd6) begin
            n_bad++; $display("FAIL b2b_first: got ok=%0d hi=%h lo=%h, want 0 6", ok, hi, lo);
        end
        issue_now(3'b000, 32'd100, 32'd7);
        wait_done(e, bc, ok);
        n_cmp++;
        if (!ok || e !== 33 || hi !== 32'd2 || lo !== 32'd14) begin
            n_bad++; $display("FAIL b2b_second: got ok=%0d edges=%0d hi=%h lo=%h, want 33 2 e", ok, e, hi, lo);
        end
    endtask

`ifdef MULDIV_ABORT_EN
    task automatic test_abort;
        bit seen;
        issue(3'b100, 32'h0BAD, 32'h0);
        issue(3'b101, 32'h0FEE, 32'h0);
        issue(3'b000, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0BAD || lo !== 32'h0FEE) begin
            n_bad++; $display("FAIL abort: got busy=%b done=%b hi=%h lo=%h, want 0 0 bad fee", busy, done, hi, lo);
        end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin n_bad++; $display("FAIL abort_no_done: got done seen=%b, want 0", seen); end
    endtask
`endif

    initial begin
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_mt_divzero();
        test_busy_ignore_and_reset();
        test_back_to_back();
`ifdef MULDIV_ABORT_EN
        test_abort();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
